// File: rtl/param_stack.sv
// Parametrised LIFO stack with one-cycle registered pop data/valid. Simultaneous push+pop replaces the top entry.
// `define STACK_ERR_EN adds sticky overflow/underflow flags with a synchronous clear.
module param_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
`ifdef STACK_ERR_EN
  input  logic             err_clr,
  output logic             err_ovf,
  output logic             err_unf,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             rd_en, wr_en;
  logic [AW-1:0]    top_addr, wr_addr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    rd_en    = pop && !empty;
    // A push while full only proceeds as a replace-top, which needs a pop alongside it.
    wr_en    = push && (pop || !full);
    top_addr = AW'(count_q - CW'(1));
    wr_addr  = rd_en ? top_addr : AW'(count_q);

    count_d = count_q;
    if (push && !pop && !full) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push && !empty) begin
      count_d = count_q - CW'(1);
    end else if (push && pop && empty) begin
      count_d = CW'(1);
    end

    dout_d       = rd_en ? mem_q[top_addr] : dout_q;
    dout_valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is deliberately left out of reset; count alone defines what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;

`ifdef STACK_ERR_EN
  logic err_ovf_q, err_unf_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= (push && !pop && full) || (err_ovf_q && !err_clr);
      err_unf_q <= (pop && empty) || (err_unf_q && !err_clr);
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (WIDTH=16, DEPTH=4) against a queue-based reference model.
module tb_param_stack;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
`ifdef STACK_ERR_EN
  logic          err_clr = 1'b0;
  logic          err_ovf;
  logic          err_unf;
`endif

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .push       (push),
    .pop        (pop),
    .din        (din),
`ifdef STACK_ERR_EN
    .err_clr    (err_clr),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the stack is a queue whose back is the top.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovf;
  logic         m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},      32'(count),      32'(mq.size()));
    chk({tag, ".empty"},      32'(empty),      32'(mq.size() == 0));
    chk({tag, ".full"},       32'(full),       32'(mq.size() == D));
    chk({tag, ".dout"},       32'(dout),       32'(m_dout));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
`ifdef STACK_ERR_EN
    chk({tag, ".err_ovf"},    32'(err_ovf),    32'(m_ovf));
    chk({tag, ".err_unf"},    32'(err_unf),    32'(m_unf));
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic [W-1:0] d, input logic c);
    logic so;
    logic su;
    so = 1'b0;
    su = 1'b0;
    m_valid = 1'b0;
    if (p && o) begin
      if (mq.size() > 0) begin
        m_dout = mq.pop_back();
        mq.push_back(d);
        m_valid = 1'b1;
      end else begin
        mq.push_back(d);
        su = 1'b1;
      end
    end else if (p) begin
      if (mq.size() < D) mq.push_back(d);
      else so = 1'b1;
    end else if (o) begin
      if (mq.size() > 0) begin
        m_dout = mq.pop_back();
        m_valid = 1'b1;
      end else begin
        su = 1'b1;
      end
    end
    m_ovf = so || (m_ovf && !c);
    m_unf = su || (m_unf && !c);
  endtask

  task automatic step(input string tag, input logic p, input logic o, input logic [W-1:0] d, input logic c);
    @(negedge clk);
    push = p;
    pop  = o;
    din  = d;
`ifdef STACK_ERR_EN
    err_clr = c;
`endif
    @(posedge clk);
    model_step(p, o, d, c);
    #1;
    push = 1'b0;
    pop  = 1'b0;
`ifdef STACK_ERR_EN
    err_clr = 1'b0;
`endif
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    clr_n = 1'b1;
    step("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Basic LIFO order
    step("push1", 1'b1, 1'b0, 16'h1111, 1'b0);
    step("push2", 1'b1, 1'b0, 16'h2222, 1'b0);
    step("push3", 1'b1, 1'b0, 16'h3333, 1'b0);
    step("pop3",  1'b0, 1'b1, 16'h0000, 1'b0);
    step("pop2",  1'b0, 1'b1, 16'h0000, 1'b0);
    step("pop1",  1'b0, 1'b1, 16'h0000, 1'b0);
    step("idle2", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Fill, overflow attempt, replace-top while full, drain
    step("fill1", 1'b1, 1'b0, 16'hA001, 1'b0);
    step("fill2", 1'b1, 1'b0, 16'hA002, 1'b0);
    step("fill3", 1'b1, 1'b0, 16'hA003, 1'b0);
    step("fill4", 1'b1, 1'b0, 16'hA004, 1'b0);
    step("ovf",   1'b1, 1'b0, 16'hDEAD, 1'b0);
    step("popf",  1'b0, 1'b1, 16'h0000, 1'b0);
    step("fill5", 1'b1, 1'b0, 16'hA005, 1'b0);
    step("rtfull",1'b1, 1'b1, 16'hBEEF, 1'b0);
    repeat (4) step("drain", 1'b0, 1'b1, 16'h0000, 1'b0);

    // Underflow, then error clear
    step("unf",   1'b0, 1'b1, 16'h0000, 1'b0);
    step("eclr",  1'b0, 1'b0, 16'h0000, 1'b1);
    step("idle3", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Replace-top at count=1, and push+pop on empty
    step("pushAA",1'b1, 1'b0, 16'h00AA, 1'b0);
    step("rtop",  1'b1, 1'b1, 16'h00BB, 1'b0);
    step("popBB", 1'b0, 1'b1, 16'h0000, 1'b0);
    step("ppemp", 1'b1, 1'b1, 16'h00CC, 1'b0);
    step("popCC", 1'b0, 1'b1, 16'h0000, 1'b0);
    step("setclr",1'b0, 1'b1, 16'h0000, 1'b1);

    // Asynchronous reset mid-burst with count=3
    step("b1", 1'b1, 1'b0, 16'h0B01, 1'b0);
    step("b2", 1'b1, 1'b0, 16'h0B02, 1'b0);
    step("b3", 1'b1, 1'b1, 16'h0B03, 1'b0);
    step("b4", 1'b1, 1'b0, 16'h0B04, 1'b0);
    @(negedge clk);
    push = 1'b1;
    din  = 16'h0B05;
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    push = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    step("post1", 1'b1, 1'b0, 16'h5A5A, 1'b0);
    step("post2", 1'b0, 1'b1, 16'h0000, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic p;
      logic o;
      logic c;
      p = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 15) == 0);
      step("rand", p, o, W'($urandom), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
